imm_field_decoder: RTL and testbench
====================================

Name: imm_field_decoder

Overview:
- Decode-side producer of the immediate fields that the immediate select path consumes.
- Accepts raw 32-bit instruction words from fetch over a valid/ready handshake.
- Splits each word into the memory-format immediate, the I-type immediate and the format bit (instr[27]), plus a pre-selected, sign-extended 32-bit immediate.
- Presents the decoded bundle to the execute side through a 2-entry skid buffer, so both handshakes are fully registered and back-pressure never drops a word.

Parameters:
- IW, 32, instruction width
- IMMW, 16, immediate field width
- XW, 32, extended immediate width (XW >= IMMW)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_instr  input  IW  instruction word from fetch
- in_valid  input  1  in_instr is valid
- in_ready  output  1  block can accept in_instr this cycle
- mem_type  output  IMMW  memory-format immediate, instr[15:0]
- I_type  output  IMMW  I-type immediate, instr[20:5]
- I27  output  1  format select, instr[27]
- imm_sel  output  XW  sign-extended (I27 ? mem_type : I_type)
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  consumer accepts bundle
- dec_count  output  16  number of bundles delivered, wraps

Behaviour:
Handshake rules
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- Storage is a main register, which drives the outputs, and a skid register. Each has its own valid bit.
- in_ready = !skid_valid. It depends on registered state only, with no combinational path from out_ready.
- out_valid = main_valid.

Latency and data flow
- Latency is 1 cycle: a word accepted at edge N appears on the outputs after edge N, provided main is empty or draining.
- Decode happens at capture time. All output fields are registered, never combinational from in_instr.
- Per clock edge, when flush = 0:
  - Main empty or draining (!main_valid || out_ready):
    - If skid_valid: main <= skid, skid_valid <= 0. An input transfer in the same cycle loads main instead; it cannot coexist because in_ready = 0 whenever skid_valid.
    - Else: main <= input if transferred, otherwise main_valid <= 0.
  - Main full and stalled: an input transfer writes skid, skid_valid <= 1.
- Output data is held stable while out_valid && !out_ready.

Arithmetic and width rules
- imm_sel = {{(XW-IMMW){sel[IMMW-1]}}, sel}, where sel = I27 ? mem_type : I_type.
- dec_count increments by 1 on each output transfer and wraps 0xFFFF -> 0x0000.

Flush
- Synchronous; clears main_valid and skid_valid on the edge.
- Any input offered in the flush cycle is dropped, even if in_ready = 1.
- Any output transfer in the flush cycle still counts.
- Data registers are not cleared.

Reset (asynchronous, while rst_n = 0)
- main_valid = skid_valid = 0, out_valid = 0, in_ready = 1.
- mem_type = I_type = 0, I27 = 0, imm_sel = 0, dec_count = 0.
- Reset mid-transfer discards all buffered words.
- The first transfer is possible on the first rising edge after rst_n deasserts.

Boundary conditions
- Both entries full (in_ready = 0) with out_ready = 1: main takes skid, and in_ready returns to 1 the next cycle.
- Full throughput of 1 word/cycle is sustained while out_ready = 1.
- No word is duplicated or reordered under any out_ready pattern.

Test Plan:
- Reset then single word: in_instr=0x0800_8004, in_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1, I27=1, mem_type=0x8004, imm_sel=0xFFFF_8004, dec_count becomes 1 after transfer.
- I-type sign extension: in_instr=0x0001_FFE0 (bit27=0) -> I_type=0x0FFF, I27=0, imm_sel=0x0000_0FFF; in_instr=0x0010_0000 -> I_type=0x8000, imm_sel=0xFFFF_8000.
- Back-pressure: stream words A,B,C at 1/cycle with out_ready=0 -> A held on outputs, B in skid, in_ready=0, C held by source; raise out_ready -> outputs A,B,C in order on consecutive cycles, no loss or duplicate, dec_count=3.
- Random out_ready (50%) over 1000 random words -> scoreboard order and field values match, dec_count = delivered count mod 65536.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered word is absent from the output stream.
- Async reset asserted mid-stream between clock edges -> out_valid and all fields go to 0 immediately, dec_count=0; stream restarts cleanly after release.

Source files
------------

// File: rtl/imm_field_decoder.sv
// rtl/imm_field_decoder.sv - instruction immediate field decoder with 2-entry skid buffer
// Fields are decoded at capture time; main register drives outputs, skid absorbs one stalled word.
module imm_field_decoder #(
  parameter int IW   = 32,
  parameter int IMMW = 16,
  parameter int XW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [IW-1:0]   in_instr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [IMMW-1:0] mem_type,
  output logic [IMMW-1:0] I_type,
  output logic            I27,
  output logic [XW-1:0]   imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     dec_count
);

  localparam int BW = 2 * IMMW + 1 + XW;

  logic [IMMW-1:0] w_mem;
  logic [IMMW-1:0] w_itype;
  logic [IMMW-1:0] w_sel;
  logic            w_i27;
  logic [XW-1:0]   w_ext;
  logic [BW-1:0]   w_dec;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_drain;
  logic            w_unused_instr;

  logic [BW-1:0]   r_main_data;
  logic [BW-1:0]   r_skid_data;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic [15:0]     r_count;

  assign w_mem   = in_instr[IMMW-1:0];
  assign w_itype = in_instr[IMMW+4:5];
  assign w_i27   = in_instr[27];
  assign w_sel   = w_i27 ? w_mem : w_itype;
  assign w_ext   = {{(XW-IMMW){w_sel[IMMW-1]}}, w_sel};
  assign w_dec   = {w_mem, w_itype, w_i27, w_ext};
  assign w_unused_instr = ^in_instr;

  // in_ready depends on registered state only, never on out_ready
  assign w_in_fire  = in_valid && !r_skid_valid;
  assign w_out_fire = r_main_valid && out_ready;
  assign w_drain    = !r_main_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data  <= '0;
      r_skid_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_out_fire) begin
        r_count <= r_count + 16'd1;
      end
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_drain) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_main_valid <= w_in_fire;
          if (w_in_fire) begin
            r_main_data <= w_dec;
          end
        end
      end else if (w_in_fire) begin
        r_skid_data  <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign {mem_type, I_type, I27, imm_sel} = r_main_data;
  assign dec_count = r_count;

endmodule

// File: tb/tb_imm_field_decoder.sv
// tb/tb_imm_field_decoder.sv - directed and scoreboard bench for imm_field_decoder
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_imm_field_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_type;
  logic [15:0] I_type;
  logic        I27;
  logic [31:0] imm_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dec_count;

  int checks = 0;
  int errors = 0;

  imm_field_decoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .mem_type(mem_type), .I_type(I_type), .I27(I27), .imm_sel(imm_sel),
    .out_valid(out_valid), .out_ready(out_ready), .dec_count(dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [31:0] w);
    logic [15:0] s;
    s = w[27] ? w[15:0] : w[20:5];
    return {w[15:0], w[20:5], w[27], {{16{s[15]}}, s}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] exp_w;
  int sent;
  int delivered;
  int exp_cnt;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_instr = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_fields", {mem_type, I_type, I27, imm_sel}, 65'd0);
    check("rst_count", dec_count, 16'd0);
    #2 rst_n = 1'b1;

    // single memory-format word
    in_instr = 32'h0800_8004; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("w1_valid", out_valid, 1'b1);
    check("w1_i27", I27, 1'b1);
    check("w1_mem", mem_type, 16'h8004);
    check("w1_itype", I_type, 16'h0400);
    check("w1_imm", imm_sel, 32'hFFFF_8004);
    check("w1_cnt_before", dec_count, 16'd0);
    step();
    check("w1_drained", out_valid, 1'b0);
    check("w1_cnt", dec_count, 16'd1);

    // I-type sign extension, back to back
    in_instr = 32'h0001_FFE0; in_valid = 1'b1;
    step();
    check("it1_itype", I_type, 16'h0FFF);
    check("it1_i27", I27, 1'b0);
    check("it1_imm", imm_sel, 32'h0000_0FFF);
    in_instr = 32'h0010_0000;
    step();
    in_valid = 1'b0;
    check("it2_valid", out_valid, 1'b1);
    check("it2_itype", I_type, 16'h8000);
    check("it2_imm", imm_sel, 32'hFFFF_8000);
    step();
    check("it_cnt", dec_count, 16'd3);

    // back-pressure: A in main, B in skid, C held by source
    out_ready = 1'b0;
    in_instr = 32'h0800_1234; in_valid = 1'b1;
    step();
    check("bp_a_ready", in_ready, 1'b1);
    in_instr = 32'h0800_ABCD;
    step();
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_a_held", mem_type, 16'h1234);
    in_instr = 32'h0000_0020;
    step();
    check("bp_a_still", imm_sel, 32'h0000_1234);
    check("bp_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("bp_b_out", imm_sel, 32'hFFFF_ABCD);
    check("bp_ready_back", in_ready, 1'b1);
    check("bp_cnt4", dec_count, 16'd4);
    step();
    in_valid = 1'b0;
    check("bp_c_out", {out_valid, I27, I_type, imm_sel}, {1'b1, 1'b0, 16'h0001, 32'h0000_0001});
    step();
    check("bp_empty", out_valid, 1'b0);
    check("bp_cnt6", dec_count, 16'd6);

    // flush with both entries full and a word offered
    out_ready = 1'b0;
    in_instr = 32'h0800_1111; in_valid = 1'b1;
    step();
    in_instr = 32'h0800_2222;
    step();
    in_instr = 32'h0800_3333; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 1'b0);
    check("fl_ready", in_ready, 1'b1);
    step();
    check("fl_dropped", out_valid, 1'b0);
    check("fl_cnt", dec_count, 16'd6);

    // an output transfer in the flush cycle still counts
    in_instr = 32'h0000_0040; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_xfer_cnt", dec_count, 16'd7);
    check("fl_xfer_valid", out_valid, 1'b0);
    exp_cnt = 7;

    // random words with random back-pressure
    sent = 0; delivered = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (sent >= 1000 && sb.size() == 0) break;
      out_ready = $urandom_range(0, 1) == 1;
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_instr = $urandom();
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_spurious", 1'b1, 1'b0);
        end else begin
          exp_w = sb.pop_front();
          check("rnd_bundle", {mem_type, I_type, I27, imm_sel}, model(exp_w));
        end
        delivered++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_instr);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    check("rnd_sent", sent, 1000);
    check("rnd_drained", sb.size(), 0);
    check("rnd_cnt", dec_count, 16'((exp_cnt + delivered) % 65536));

    // async reset between edges with both entries full
    out_ready = 1'b0;
    in_instr = 32'h0800_F00D; in_valid = 1'b1;
    step();
    in_instr = 32'h0800_BEEF;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_fields", {mem_type, I_type, I27, imm_sel}, 65'd0);
    check("ar_cnt", dec_count, 16'd0);
    check("ar_ready", in_ready, 1'b1);
    #3 rst_n = 1'b1;
    in_instr = 32'h0800_8004; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("ar_restart", {out_valid, imm_sel}, {1'b1, 32'hFFFF_8004});
    step();
    check("ar_restart_cnt", {out_valid, dec_count}, {1'b0, 16'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
